// File: rtl/uart_tx.sv
// uart_tx: 11-bit UART frame serialiser (start, 8 data MSB first, even parity, stop).
// Each bit is held CLKS_PER_BIT cycles of clk_3125. tx is driven from a register.
// Optional input FIFO enabled by defining UART_TX_FIFO_EN (depth FIFO_DEPTH, power of two >= 2).
// Without the macro the block accepts one byte at a time, only while idle.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 27,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk_3125,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned    CntW    = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;      // 1..CLKS_PER_BIT inside a bit, 0 when idle
  logic [2:0]      bit_q, bit_d;      // data bit index, 7 down to 0
  logic [7:0]      shift_q, shift_d;  // byte being sent, current bit at [7]
  logic            par_q, par_d;      // parity captured with the byte
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            bit_end;           // last cycle of the current bit
  logic            start_req;         // a new frame begins on this edge
  logic [7:0]      load_byte;         // byte loaded when start_req is high

  assign bit_end = (cnt_q == CntLast);

`ifdef UART_TX_FIFO_EN
  localparam int unsigned AddrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   count_q;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  // Full is judged before any pop on the same edge, so a push into a full
  // FIFO is dropped even while the head is leaving.
  assign fifo_full  = (count_q == (AddrW + 1)'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = tx_valid && !fifo_full && rst_n;
  // Pop when idle, or on the last stop-bit cycle so the next start bit follows immediately.
  assign pop        = !fifo_empty && rst_n &&
                      ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end));

  assign tx_ready   = !fifo_full;
  assign start_req  = pop;
  // Head is read combinationally so it can be loaded on the same edge it is popped.
  assign load_byte  = fifo_mem[rd_ptr_q];

  // FIFO storage write; contents need no reset because the pointers gate reads.
  always_ff @(posedge clk_3125) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= tx_data;
    end
  end

  // FIFO pointers and occupancy; reset flushes the queue.
  always_ff @(posedge clk_3125) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AddrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AddrW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (AddrW + 1)'(1);
        2'b01:   count_q <= count_q - (AddrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end
`else
  // Single-entry mode: the byte goes straight into the shift register.
  assign tx_ready  = (state_q == S_IDLE);
  assign start_req = tx_valid && tx_ready && rst_n;
  assign load_byte = tx_data;

  logic unused_fifo_depth;
  assign unused_fifo_depth = (FIFO_DEPTH > 0);
`endif

  // State and datapath registers; reset aborts any frame and returns the line high.
  always_ff @(posedge clk_3125) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: tx_d only changes at bit boundaries, so tx never glitches.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (start_req) begin
          state_d = S_START;
          shift_d = load_byte;
          par_d   = ^load_byte;
          cnt_d   = CntW'(1);
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end

      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = 3'd7;
          cnt_d   = CntW'(1);
          tx_d    = shift_q[7];
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      S_DATA: begin
        if (bit_end) begin
          cnt_d = CntW'(1);
          if (bit_q == 3'd0) begin
            state_d = S_PARITY;
            tx_d    = par_q;
          end else begin
            bit_d   = bit_q - 3'd1;
            shift_d = {shift_q[6:0], 1'b0};
            tx_d    = shift_q[6];
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          cnt_d   = CntW'(1);
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      S_STOP: begin
        if (bit_end) begin
          done_d = 1'b1;
          if (start_req) begin
            // Back-to-back frame: start bit follows the stop bit with no idle cycle.
            state_d = S_START;
            shift_d = load_byte;
            par_d   = ^load_byte;
            cnt_d   = CntW'(1);
            tx_d    = 1'b0;
            busy_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule
